instr_encoder_loader: RTL and testbench

Packs decoded instruction fields into 32-bit instruction words using the same field layout the IR decodes, and writes them sequentially into instruction memory. It is the producer side of the instruction path: it fills program memory that the fetch path later drives onto BusMuxOut. It accepts field tuples over a valid/ready handshake and writes each word through a single-outstanding mem_we/mem_ack interface. Loading stops when a halt is written or memory is full.

---
 rtl/instr_encoder_loader_if.sv | 33 +++
 rtl/instr_encoder_loader.sv | 174 +++++++++++++++++
 tb/tb_instr_encoder_loader.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_loader_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | instr_encoder_loader_if: tuple handshake and memory write bus            |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
interface instr_encoder_loader_if #(
  parameter int ADDR_W = 9
);
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        Opcode;
  logic [3:0]        Ra;
  logic [3:0]        Rb;
  logic [3:0]        Rc;
  logic [18:0]       C;
  logic [3:0]        C2;
  logic [22:0]       Jaddr;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_data;
  logic              mem_ack;

  modport master (
    output in_valid, Opcode, Ra, Rb, Rc, C, C2, Jaddr, mem_ack,
    input  in_ready, mem_we, mem_addr, mem_data
  );

  modport slave (
    input  in_valid, Opcode, Ra, Rb, Rc, C, C2, Jaddr, mem_ack,
    output in_ready, mem_we, mem_addr, mem_data
  );
endinterface
`default_nettype wire

// File: rtl/instr_encoder_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | instr_encoder_loader: packs field tuples into IR-format words, loads mem |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module instr_encoder_loader #(
  parameter int ADDR_W      = 9,
  parameter int START_ADDR  = 0,
  parameter int ACK_TIMEOUT = 15
) (
  input  wire logic                Clock,
  input  wire logic                Clear,
  input  wire logic                start,
  instr_encoder_loader_if.slave    bus,
  output logic                     busy,
  output logic                     done,
  output logic                     halted,
  output logic                     full,
  output logic                     timeout,
  output logic                     illegal,
  output logic [ADDR_W:0]          word_count,
  output logic [7:0]               err_count
);

  localparam int         WAIT_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [4:0] OP_HALT   = 5'b11011;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCEPT = 2'd1,
    S_WRITE  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_data_q, mem_data_d;
  logic [ADDR_W:0]     word_count_q, word_count_d;
  logic [7:0]          err_count_q, err_count_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                halted_q, halted_d;
  logic                full_q, full_d;
  logic                timeout_q, timeout_d;
  logic                illegal_q, illegal_d;

  logic [31:0]         enc_word;
  logic                enc_legal;
  logic                last_addr;

  // Field placement mirrors the IR decode; unused bits stay zero.
  always_comb begin
    enc_word  = '0;
    enc_legal = 1'b1;
    case (bus.Opcode) inside
      [5'd0:5'd2], [5'd12:5'd14]: enc_word = {bus.Opcode, bus.Ra, bus.Rb, bus.C};
      [5'd3:5'd11]:               enc_word = {bus.Opcode, bus.Ra, bus.Rb, bus.Rc, 15'd0};
      [5'd15:5'd18]:              enc_word = {bus.Opcode, bus.Ra, bus.Rb, 19'd0};
      5'd19:                      enc_word = {bus.Opcode, bus.Ra, bus.C2, bus.C};
      [5'd20:5'd21]:              enc_word = {bus.Opcode, bus.Ra, bus.Jaddr};
      [5'd22:5'd25]:              enc_word = {bus.Opcode, bus.Ra, 23'd0};
      [5'd26:5'd27]:              enc_word = {bus.Opcode, 27'd0};
      default:                    enc_legal = 1'b0;
    endcase
  end

  assign last_addr = (addr_q == {ADDR_W{1'b1}});

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    word_count_d = word_count_q;
    err_count_d  = err_count_q;
    wait_d       = wait_q;
    halted_d     = halted_q;
    full_d       = full_q;
    timeout_d    = timeout_q;
    illegal_d    = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d      = S_ACCEPT;
          addr_d       = ADDR_W'(START_ADDR);
          word_count_d = '0;
          err_count_d  = '0;
          halted_d     = 1'b0;
          full_d       = 1'b0;
          timeout_d    = 1'b0;
        end
      end
      S_ACCEPT: begin
        if (bus.in_valid) begin
          if (enc_legal) begin
            mem_data_d = enc_word;
            mem_addr_d = addr_q;
            wait_d     = '0;
            state_d    = S_WRITE;
          end else begin
            illegal_d = 1'b1;
            if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
          end
        end
      end
      S_WRITE: begin
        if (bus.mem_ack) begin
          word_count_d = word_count_q + {{ADDR_W{1'b0}}, 1'b1};
          // The address saturates at the top word rather than wrapping.
          if (!last_addr) addr_d = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
          if (mem_data_q[31:27] == OP_HALT) begin
            state_d  = S_DONE;
            halted_d = 1'b1;
          end else if (last_addr) begin
            state_d = S_DONE;
            full_d  = 1'b1;
          end else begin
            state_d = S_ACCEPT;
          end
        end else if (wait_q == WAIT_W'(ACK_TIMEOUT - 1)) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      word_count_q <= '0;
      err_count_q  <= '0;
      wait_q       <= '0;
      halted_q     <= 1'b0;
      full_q       <= 1'b0;
      timeout_q    <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      word_count_q <= word_count_d;
      err_count_q  <= err_count_d;
      wait_q       <= wait_d;
      halted_q     <= halted_d;
      full_q       <= full_d;
      timeout_q    <= timeout_d;
      illegal_q    <= illegal_d;
    end
  end

  assign bus.in_ready = (state_q == S_ACCEPT);
  assign bus.mem_we   = (state_q == S_WRITE);
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_data = mem_data_q;
  assign busy         = (state_q == S_ACCEPT) || (state_q == S_WRITE);
  assign done         = (state_q == S_DONE);
  assign halted       = halted_q;
  assign full         = full_q;
  assign timeout      = timeout_q;
  assign illegal      = illegal_q;
  assign word_count   = word_count_q;
  assign err_count    = err_count_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_instr_encoder_loader: directed bench for the default and 4-word loader|
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_instr_encoder_loader;

  typedef struct packed {
    logic [8:0]  addr;
    logic [31:0] data;
  } exp_t;

  logic        Clock = 1'b0;
  logic        Clear = 1'b0;
  logic        sel   = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        mem_ack  = 1'b0;
  logic [4:0]  opcode = '0;
  logic [3:0]  ra = '0, rb = '0, rc = '0, c2 = '0;
  logic [18:0] c = '0;
  logic [22:0] jaddr = '0;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 Clock = ~Clock;

  instr_encoder_loader_if #(.ADDR_W(9)) b_if ();
  instr_encoder_loader_if #(.ADDR_W(2)) s_if ();

  assign b_if.in_valid = in_valid & ~sel;
  assign s_if.in_valid = in_valid & sel;
  assign b_if.mem_ack  = mem_ack & ~sel;
  assign s_if.mem_ack  = mem_ack & sel;
  assign b_if.Opcode = opcode; assign s_if.Opcode = opcode;
  assign b_if.Ra = ra;         assign s_if.Ra = ra;
  assign b_if.Rb = rb;         assign s_if.Rb = rb;
  assign b_if.Rc = rc;         assign s_if.Rc = rc;
  assign b_if.C = c;           assign s_if.C = c;
  assign b_if.C2 = c2;         assign s_if.C2 = c2;
  assign b_if.Jaddr = jaddr;   assign s_if.Jaddr = jaddr;

  logic       b_busy, b_done, b_halted, b_full, b_timeout, b_illegal;
  logic       s_busy, s_done, s_halted, s_full, s_timeout, s_illegal;
  logic [9:0] b_wc;
  logic [2:0] s_wc;
  logic [7:0] b_ec, s_ec;

  instr_encoder_loader #(.ADDR_W(9)) u_big (
    .Clock(Clock), .Clear(Clear), .start(start & ~sel), .bus(b_if),
    .busy(b_busy), .done(b_done), .halted(b_halted), .full(b_full),
    .timeout(b_timeout), .illegal(b_illegal), .word_count(b_wc), .err_count(b_ec)
  );

  instr_encoder_loader #(.ADDR_W(2)) u_small (
    .Clock(Clock), .Clear(Clear), .start(start & sel), .bus(s_if),
    .busy(s_busy), .done(s_done), .halted(s_halted), .full(s_full),
    .timeout(s_timeout), .illegal(s_illegal), .word_count(s_wc), .err_count(s_ec)
  );

  wire logic        o_ready   = sel ? s_if.in_ready : b_if.in_ready;
  wire logic        o_we      = sel ? s_if.mem_we   : b_if.mem_we;
  wire logic [8:0]  o_addr    = sel ? {7'd0, s_if.mem_addr} : b_if.mem_addr;
  wire logic [31:0] o_data    = sel ? s_if.mem_data : b_if.mem_data;
  wire logic        o_busy    = sel ? s_busy    : b_busy;
  wire logic        o_done    = sel ? s_done    : b_done;
  wire logic        o_halted  = sel ? s_halted  : b_halted;
  wire logic        o_full    = sel ? s_full    : b_full;
  wire logic        o_timeout = sel ? s_timeout : b_timeout;
  wire logic        o_illegal = sel ? s_illegal : b_illegal;
  wire logic [9:0]  o_wc      = sel ? {7'd0, s_wc} : b_wc;
  wire logic [7:0]  o_ec      = sel ? s_ec : b_ec;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge Clock);
    start = 1'b0;
  endtask

  task automatic send(input logic [4:0] op, input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] r, input logic [18:0] k, input logic [3:0] k2,
                      input logic [22:0] j);
    int n;
    opcode = op; ra = a; rb = b; rc = r; c = k; c2 = k2; jaddr = j;
    in_valid = 1'b1;
    n = 0;
    while (!o_ready && n < 20) begin
      @(negedge Clock);
      n++;
    end
    chk("handshake_ready", o_ready, 1);
    @(negedge Clock);
    in_valid = 1'b0;
  endtask

  task automatic wait_we(input string tag);
    int n;
    n = 0;
    while (!o_we && n < 20) begin
      @(negedge Clock);
      n++;
    end
    chk({tag, "_we"}, o_we, 1);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 0, 1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_addr"}, o_addr, e.addr);
      chk({tag, "_data"}, o_data, e.data);
    end
  endtask

  task automatic expect_write(input string tag, input int ack_delay);
    wait_we(tag);
    pop_check(tag);
    if (ack_delay > 0) begin
      repeat (ack_delay) @(negedge Clock);
      chk({tag, "_we_held"}, o_we, 1);
    end
    mem_ack = 1'b1;
    @(negedge Clock);
    mem_ack = 1'b0;
  endtask

  initial begin
    int n;
    // Reset state
    repeat (2) @(negedge Clock);
    chk("rst_ready", o_ready, 0);
    chk("rst_we", o_we, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_addr", o_addr, 0);
    chk("rst_data", o_data, 0);
    chk("rst_wc", o_wc, 0);
    chk("rst_ec", o_ec, 0);
    Clear = 1'b1;
    @(negedge Clock);
    chk("idle_ready", o_ready, 0);

    pulse_start();
    chk("accept_busy", o_busy, 1);
    chk("accept_ready", o_ready, 1);

    // add with C set to all ones: C must be ignored in this format
    send(5'b00011, 4'd1, 4'd2, 4'd3, 19'h7FFFF, 4'd0, 23'd0);
    sb.push_back('{addr: 9'd0, data: 32'h18918000});
    expect_write("add", 2);
    chk("add_wc", o_wc, 1);
    chk("add_ready", o_ready, 1);

    send(5'b10011, 4'd5, 4'hA, 4'hB, 19'h00010, 4'd0, 23'h7FFFFF);
    sb.push_back('{addr: 9'd1, data: 32'h9A800010});
    expect_write("brzr", 0);
    send(5'b10101, 4'hF, 4'h3, 4'h4, 19'h12345, 4'h6, 23'h7FFFFF);
    sb.push_back('{addr: 9'd2, data: 32'hAFFFFFFF});
    expect_write("jal", 0);
    chk("jal_wc", o_wc, 3);

    // Illegal opcode is dropped with a one-cycle pulse
    send(5'b11100, 4'd1, 4'd1, 4'd1, 19'd1, 4'd1, 23'd1);
    chk("ill_pulse", o_illegal, 1);
    chk("ill_ec", o_ec, 1);
    chk("ill_ready", o_ready, 1);
    chk("ill_we", o_we, 0);
    @(negedge Clock);
    chk("ill_pulse_end", o_illegal, 0);

    send(5'b11011, 4'd7, 4'd7, 4'd7, 19'h1, 4'h1, 23'h1);
    sb.push_back('{addr: 9'd3, data: 32'hD8000000});
    expect_write("halt", 0);
    chk("halt_done", o_done, 1);
    chk("halt_halted", o_halted, 1);
    chk("halt_full", o_full, 0);
    chk("halt_ready", o_ready, 0);
    chk("halt_busy", o_busy, 0);
    chk("halt_wc", o_wc, 4);
    chk("halt_ec", o_ec, 1);

    // Stray ack outside WRITE
    mem_ack = 1'b1;
    @(negedge Clock);
    mem_ack = 1'b0;
    chk("stray_ack_wc", o_wc, 4);

    pulse_start();
    chk("restart_wc", o_wc, 0);
    chk("restart_ec", o_ec, 0);
    chk("restart_halted", o_halted, 0);
    chk("restart_done", o_done, 0);
    send(5'b11010, 4'd9, 4'd9, 4'd9, 19'h5, 4'h5, 23'h5);
    sb.push_back('{addr: 9'd0, data: 32'hD0000000});
    pulse_start();
    chk("start_in_write_we", o_we, 1);
    expect_write("nop0", 0);
    chk("nop0_wc", o_wc, 1);

    // Ack never arrives
    send(5'b11010, 4'd0, 4'd0, 4'd0, 19'd0, 4'd0, 23'd0);
    sb.push_back('{addr: 9'd1, data: 32'hD0000000});
    wait_we("tmo");
    pop_check("tmo");
    n = 0;
    while (o_we && n < 40) begin
      @(negedge Clock);
      n++;
    end
    chk("tmo_cycles", n, 15);
    chk("tmo_flag", o_timeout, 1);
    chk("tmo_done", o_done, 1);
    chk("tmo_wc", o_wc, 1);

    // Clear in the middle of a write
    pulse_start();
    chk("rs_timeout_clr", o_timeout, 0);
    send(5'b11010, 4'd0, 4'd0, 4'd0, 19'd0, 4'd0, 23'd0);
    sb.push_back('{addr: 9'd0, data: 32'hD0000000});
    wait_we("clr");
    pop_check("clr");
    #2 Clear = 1'b0;
    #1;
    chk("clr_we", o_we, 0);
    chk("clr_busy", o_busy, 0);
    chk("clr_done", o_done, 0);
    chk("clr_addr", o_addr, 0);
    chk("clr_data", o_data, 0);
    chk("clr_wc", o_wc, 0);
    @(negedge Clock);
    Clear = 1'b1;
    @(negedge Clock);

    // Four-word memory fills up
    sel = 1'b1;
    @(negedge Clock);
    chk("s_idle_ready", o_ready, 0);
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      send(5'b11010, 4'(i), 4'd0, 4'd0, 19'd0, 4'd0, 23'd0);
      sb.push_back('{addr: 9'(i), data: 32'hD0000000});
      expect_write("s_nop", i % 2);
    end
    chk("s_full", o_full, 1);
    chk("s_done", o_done, 1);
    chk("s_halted", o_halted, 0);
    chk("s_wc", o_wc, 4);
    opcode = 5'b11010;
    in_valid = 1'b1;
    repeat (3) @(negedge Clock);
    chk("s_fifth_ready", o_ready, 0);
    chk("s_fifth_we", o_we, 0);
    chk("s_fifth_wc", o_wc, 4);
    in_valid = 1'b0;

    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
